// File: rtl/cnt_sched.sv
// Round-robin scheduler that grants a shared up/down counter to one of two
// requesters and runs it for exactly the number of steps that requester asked for.
module cnt_sched #(
  parameter int W  = 3,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [1:0]    req,
  input  logic [1:0]    dir,
  input  logic [SW-1:0] steps0,
  input  logic [SW-1:0] steps1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          busy,
  output logic          cnt_en,
  output logic          cnt_updown,
  output logic [W-1:0]  q,
  output logic          wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic          owner;
  logic          last;
  logic          dir_l;
  logic [SW-1:0] rem;
  logic          sel;
  logic [SW-1:0] sel_steps;
  logic [1:0]    owner_oh;

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel       = (req == 2'b11) ? ~last : req[1];
    sel_steps = sel ? steps1 : steps0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req) state_nxt = (sel_steps != '0) ? RUN : DONE;
      RUN:  if (rem == SW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All strobes are decoded from registered state only.
  always_comb begin
    owner_oh   = owner ? 2'b10 : 2'b01;
    busy       = (state != IDLE);
    cnt_en     = (state == RUN);
    cnt_updown = busy & dir_l;
    gnt        = busy ? owner_oh : 2'b00;
    done       = (state == DONE) ? owner_oh : 2'b00;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      dir_l <= 1'b0;
      rem   <= '0;
      q     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= sel;
            dir_l <= dir[sel];
            rem   <= sel_steps;
          end
        end
        RUN: begin
          rem <= rem - SW'(1);
          if (dir_l) begin
            q    <= q - W'(1);
            wrap <= (q == '0);
          end else begin
            q    <= q + W'(1);
            wrap <= (q == '1);
          end
        end
        DONE: last <= owner;
        default: ;
      endcase
    end
  end

endmodule
